instr_encoder_loader: RTL and testbench

- Sequential RISC-V instruction encoder: the counterpart of the core's decode stage.
- Accepts instruction descriptors (kind, rd, rs1, rs2, imm) over a valid/ready handshake and encodes each into a 32-bit RV32I word.
- Writes each word to instruction memory at consecutive word addresses from a programmable base.
- Used for boot/self-test program loading; covers exactly the subset the core decodes: lw, sw, add, sub, and, or, slt, beq, addi, jal, lui.

---
 rtl/instr_encoder_loader_if.sv | 31 +++
 rtl/instr_encoder_loader.sv | 184 ++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Descriptor handshake and instruction-memory write bus for instr_encoder_loader.
//   in_valid/in_ready  descriptor handshake (source -> encoder)
//   in_kind..in_last   descriptor payload
//   imem_we/addr/wdata write request (encoder -> memory)
//   imem_ready         memory accepts the write when imem_we=1
// slave  : encoder side
// master : descriptor source and memory side (the environment)
interface instr_encoder_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_kind;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic        in_last;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        imem_ready;

   modport slave (
      input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_last, imem_ready,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_last, imem_ready,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// Sequential RV32I encoder/loader. Takes instruction descriptors, encodes
// each into a 32-bit word and writes it to instruction memory at consecutive
// word addresses starting from base_addr.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin a session (honoured only when idle)
//   base_addr      first write address, low two bits forced to zero
//   bus            descriptor handshake + imem write bus (slave modport)
//   busy           session in progress
//   done           one-cycle pulse at session end
//   err, err_code  sticky error flag and first error code (01 kind, 10 imm, 11 overflow)
//   count          words written this session
module instr_encoder_loader #(
   parameter int MAX_WORDS = 256,
   parameter int CNT_W     = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [31:0]            base_addr,
   instr_encoder_loader_if.slave  bus,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [1:0]             err_code,
   output logic [CNT_W-1:0]       count
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      word_q, word_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;

   // ---------------- encoder ----------------
   logic [31:0] imm;
   logic [4:0]  rd, rs1, rs2;
   logic        ok_i, ok_b, ok_j, ok_u;
   logic [31:0] enc_word;
   logic [1:0]  enc_err;

   assign imm = bus.in_imm;
   assign rd  = bus.in_rd;
   assign rs1 = bus.in_rs1;
   assign rs2 = bus.in_rs2;

   // Immediate must be the sign extension of the bits the format can carry.
   assign ok_i = (&imm[31:11]) | ~(|imm[31:11]);
   assign ok_b = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
   assign ok_j = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
   assign ok_u = ~(|imm[11:0]);

   always_comb begin
      enc_word = NOP;
      enc_err  = 2'b00;
      case (bus.in_kind)
         4'd0: begin
            enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            if (!ok_i) enc_err = 2'b10;
         end
         4'd1: begin
            enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            if (!ok_i) enc_err = 2'b10;
         end
         4'd2: enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
         4'd3: enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
         4'd4: enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
         4'd5: enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
         4'd6: enc_word = {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
         4'd7: begin
            enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            if (!ok_b) enc_err = 2'b10;
         end
         4'd8: begin
            enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            if (!ok_i) enc_err = 2'b10;
         end
         4'd9: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            if (!ok_j) enc_err = 2'b10;
         end
         4'd10: begin
            enc_word = {imm[31:12], rd, 7'b0110111};
            if (!ok_u) enc_err = 2'b10;
         end
         default: enc_err = 2'b01;
      endcase
      // A rejected descriptor still occupies its slot so later code keeps its layout.
      if (enc_err != 2'b00) enc_word = NOP;
   end

   // ---------------- control ----------------
   logic [CNT_W-1:0] count_inc;
   assign count_inc = count_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_d     = word_q;
      last_d     = last_q;
      count_d    = count_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d     = {base_addr[31:2], 2'b00};
               count_d    = '0;
               err_d      = 1'b0;
               err_code_d = 2'b00;
               state_d    = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (bus.in_valid) begin
               word_d = enc_word;
               last_d = bus.in_last;
               if (enc_err != 2'b00) begin
                  err_d = 1'b1;
                  if (err_code_q == 2'b00) err_code_d = enc_err;
               end
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (bus.imem_ready) begin
               addr_d  = addr_q + 32'd4;
               count_d = count_inc;
               if (last_q) begin
                  state_d = S_DONE;
               end else if (count_inc == CNT_W'(MAX_WORDS)) begin
                  err_d = 1'b1;
                  if (err_code_q == 2'b00) err_code_d = 2'b11;
                  state_d = S_DONE;
               end else begin
                  state_d = S_ACCEPT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         word_q     <= '0;
         last_q     <= 1'b0;
         count_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         last_q     <= last_d;
         count_q    <= count_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   // low address bits are intentionally discarded
   logic unused_base;
   assign unused_base = ^base_addr[1:0];

   assign bus.in_ready   = (state_q == S_ACCEPT);
   assign bus.imem_we    = (state_q == S_WRITE);
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = word_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign err            = err_q;
   assign err_code       = err_code_q;
   assign count          = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: descriptors are driven in order, each expected {addr, word}
// is queued when driven and checked when the write request appears.
module tb_instr_encoder_loader;
   localparam int MAXW  = 4;
   localparam int CNT_W = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [31:0]      base_addr;
   logic             busy, done, err;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] count;

   instr_encoder_loader_if bus ();

   instr_encoder_loader #(.MAX_WORDS(MAXW), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code),
      .count     (count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [63:0] sb_q[$];
   logic [31:0] exp_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic begin_session(input logic [31:0] b);
      start     = 1'b1;
      base_addr = b;
      @(negedge clk);
      start     = 1'b0;
      exp_addr  = {b[31:2], 2'b00};
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("err_cleared", {29'd0, err, err_code}, 32'd0);
      chk("count_cleared", 32'(count), 32'd0);
   endtask

   // Called at a negedge; returns at the negedge after the write completes.
   task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                       input logic [31:0] exp_w, input int hold);
      logic [63:0] e;
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_accept", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_kind  = k;
      bus.in_rd    = rd;
      bus.in_rs1   = rs1;
      bus.in_rs2   = rs2;
      bus.in_imm   = imm;
      bus.in_last  = last;
      sb_q.push_back({exp_addr, exp_w});
      exp_addr = exp_addr + 32'd4;
      bus.imem_ready = (hold == 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("imem_we_latency", {31'd0, bus.imem_we}, 32'd1);
      chk("in_ready_in_write", {31'd0, bus.in_ready}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("we_held", {31'd0, bus.imem_we}, 32'd1);
         chk("addr_held", bus.imem_addr, sb_q[0][63:32]);
         chk("wdata_held", bus.imem_wdata, sb_q[0][31:0]);
         chk("in_ready_held", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.imem_ready = 1'b1;
      e = sb_q.pop_front();
      chk("imem_addr", bus.imem_addr, e[63:32]);
      chk("imem_wdata", bus.imem_wdata, e[31:0]);
      @(negedge clk);
   endtask

   // Called right after the final write: expects the done pulse now, gone next cycle.
   task automatic end_session(input int exp_cnt, input logic exp_err, input logic [1:0] exp_code);
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("count_final", 32'(count), 32'(exp_cnt));
      chk("err_final", {31'd0, err}, {31'd0, exp_err});
      chk("err_code_final", {30'd0, err_code}, {30'd0, exp_code});
      @(negedge clk);
      chk("done_single", {31'd0, done}, 32'd0);
      chk("idle_after_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0;
      bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_rd = '0; bus.in_rs1 = '0;
      bus.in_rs2 = '0; bus.in_imm = '0; bus.in_last = 1'b0; bus.imem_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
      chk("rst_imem_addr", bus.imem_addr, 32'd0);
      chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
      chk("rst_status", {27'd0, busy, done, err, err_code}, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // single addi
      begin_session(32'h100);
      send(4'd8, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 0);
      end_session(1, 1'b0, 2'b00);

      // R-type / load / store stream; last on the MAX_WORDS-th word wins over overflow
      begin_session(32'h100);
      send(4'd2, 5'd3, 5'd1, 5'd2, 32'd0,  1'b0, 32'h002081B3, 0);
      send(4'd3, 5'd3, 5'd1, 5'd2, 32'd0,  1'b0, 32'h402081B3, 0);
      send(4'd0, 5'd5, 5'd2, 5'd0, 32'd8,  1'b0, 32'h00812283, 0);
      send(4'd1, 5'd0, 5'd2, 5'd5, 32'd12, 1'b1, 32'h00512623, 0);
      end_session(4, 1'b0, 2'b00);

      // branch / jump / upper immediate
      begin_session(32'h200);
      send(4'd7, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0, 32'hFE208CE3, 0);
      send(4'd9, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, 32'h010000EF, 0);
      send(4'd10, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7, 0);
      end_session(3, 1'b0, 2'b00);

      // memory backpressure for 3 cycles, then or/slt
      begin_session(32'h300);
      send(4'd2, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3, 3);
      send(4'd5, 5'd4, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0020E233, 0);
      send(4'd6, 5'd4, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020A233, 0);
      end_session(3, 1'b0, 2'b00);

      // out-of-range imm then bad kind; low base bits ignored; first code kept
      begin_session(32'h403);
      send(4'd8, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h00000013, 0);
      chk("err_after_imm", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b10});
      send(4'd12, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1, 32'h00000013, 0);
      end_session(2, 1'b1, 2'b10);

      // overflow: MAX_WORDS without last
      begin_session(32'h500);
      send(4'd8, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h00100093, 0);
      send(4'd8, 5'd1, 5'd0, 5'd0, 32'd2, 1'b0, 32'h00200093, 0);
      send(4'd8, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0, 32'h00300093, 0);
      send(4'd8, 5'd1, 5'd0, 5'd0, 32'd4, 1'b0, 32'h00400093, 0);
      end_session(4, 1'b1, 2'b11);

      // reset while a write is pending
      begin_session(32'h600);
      send(4'd8, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h00100093, 0);
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b0;
      bus.imem_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("pre_rst_we", {31'd0, bus.imem_we}, 32'd1);
      chk("pre_rst_count", 32'(count), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_we", {31'd0, bus.imem_we}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      rst = 1'b0;
      bus.imem_ready = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
